// File: rtl/wager_bank.sv
// Multi-player betting bank: escrows one side-bet per player per round and
// settles every player sequentially once the round outcome is latched.
module wager_bank #(
  parameter int NUM_PLAYERS = 4,
  parameter int BAL_W       = 8,
  parameter int INIT_BAL    = 100,
  parameter int COMMISSION  = 0,
  parameter int TIE_ODDS    = 8,
  localparam int PID_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   slow_clock,
  input  logic                   resetb,
  input  logic                   round_start,
  input  logic                   bet_valid,
  input  logic [PID_W-1:0]       bet_player,
  input  logic [1:0]             bet_side,
  input  logic [BAL_W-1:0]       bet_amount,
  output logic                   bet_ack,
  output logic                   bet_err,
  input  logic                   lock,
  input  logic                   result_valid,
  input  logic [1:0]             result,
  output logic                   settle_done,
  output logic                   busy,
  input  logic [PID_W-1:0]       rd_player,
  output logic [BAL_W-1:0]       rd_balance,
  output logic [NUM_PLAYERS-1:0] broke
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BETTING,
    S_LOCKED,
    S_SETTLE,
    S_DONE
  } state_e;

  localparam int EXT_W = BAL_W + 5;
  localparam logic [EXT_W-1:0] SAT_MAX  = {5'b0, {BAL_W{1'b1}}};
  localparam logic [PID_W-1:0] LAST_IDX = PID_W'(NUM_PLAYERS - 1);

  state_e state_q, state_d;

  logic [BAL_W-1:0] bal_q  [NUM_PLAYERS];
  logic [BAL_W-1:0] bal_d  [NUM_PLAYERS];
  logic [1:0]       side_q [NUM_PLAYERS];
  logic [1:0]       side_d [NUM_PLAYERS];
  logic [BAL_W-1:0] amt_q  [NUM_PLAYERS];
  logic [BAL_W-1:0] amt_d  [NUM_PLAYERS];

  logic [PID_W-1:0] idx_q, idx_d;
  logic [1:0]       res_q, res_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             pid_ok;
  logic [BAL_W-1:0] cur_bal;
  logic [BAL_W-1:0] cur_amt;
  logic [BAL_W:0]   avail;
  logic             bet_bad;

  logic [EXT_W-1:0] s_amt;
  logic [1:0]       s_side;
  logic [EXT_W-1:0] comm;
  logic [EXT_W-1:0] credit;
  logic [EXT_W-1:0] sum;
  logic [BAL_W-1:0] settled;

  // State register and all datapath flops
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      bal_q   <= '{default: BAL_W'(INIT_BAL)};
      side_q  <= '{default: 2'd0};
      amt_q   <= '{default: '0};
      idx_q   <= '0;
      res_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      side_q  <= side_d;
      amt_q   <= amt_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (round_start) state_d = S_BETTING;
      S_BETTING:      if (lock) state_d = S_LOCKED;
      S_LOCKED:       if (result_valid && (result != 2'd0)) state_d = S_SETTLE;
      S_SETTLE:       if (idx_q == LAST_IDX) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Payout for the player currently being settled, saturated to BAL_W bits
  always_comb begin
    s_amt  = {5'b0, amt_q[idx_q]};
    s_side = side_q[idx_q];
    comm   = (COMMISSION != 0) ? (s_amt / EXT_W'(20)) : '0;
    credit = '0;
    if (s_side == res_q) begin
      unique case (s_side)
        2'd1:    credit = s_amt << 1;
        2'd2:    credit = (s_amt << 1) - comm;
        2'd3:    credit = s_amt * EXT_W'(TIE_ODDS + 1);
        default: credit = '0;
      endcase
    end else if ((res_q == 2'd3) && (s_side != 2'd0)) begin
      credit = s_amt;
    end
    sum     = {5'b0, bal_q[idx_q]} + credit;
    settled = (sum > SAT_MAX) ? '1 : sum[BAL_W-1:0];
  end

  // Bet handling and settlement writes; bets only land in BETTING, so they
  // never collide with a settlement write to the same player.
  always_comb begin
    bal_d  = bal_q;
    side_d = side_q;
    amt_d  = amt_q;
    idx_d  = idx_q;
    res_d  = res_q;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    done_d = 1'b0;

    pid_ok  = 32'(bet_player) < NUM_PLAYERS;
    cur_bal = pid_ok ? bal_q[bet_player] : '0;
    cur_amt = pid_ok ? amt_q[bet_player] : '0;
    avail   = {1'b0, cur_bal} + {1'b0, cur_amt};
    bet_bad = (state_q != S_BETTING) || !pid_ok ||
              ((bet_side != 2'd0) && (bet_amount == '0)) ||
              ({1'b0, bet_amount} > avail);

    if (bet_valid) begin
      ack_d = !bet_bad;
      err_d = bet_bad;
      if (!bet_bad) begin
        bal_d[bet_player]  = BAL_W'(avail - {1'b0, bet_amount});
        side_d[bet_player] = bet_side;
        amt_d[bet_player]  = (bet_side == 2'd0) ? '0 : bet_amount;
      end
    end

    if ((state_q == S_LOCKED) && result_valid && (result != 2'd0)) begin
      res_d = result;
      idx_d = '0;
    end

    if (state_q == S_SETTLE) begin
      bal_d[idx_q]  = settled;
      side_d[idx_q] = 2'd0;
      amt_d[idx_q]  = '0;
      idx_d         = idx_q + 1'b1;
      done_d        = (idx_q == LAST_IDX);
    end
  end

  // Outputs
  always_comb begin
    bet_ack     = ack_q;
    bet_err     = err_q;
    settle_done = done_q;
    busy        = (state_q == S_LOCKED) || (state_q == S_SETTLE);
    rd_balance  = (32'(rd_player) < NUM_PLAYERS) ? bal_q[rd_player] : '0;
    broke       = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      broke[i] = (bal_q[i] == '0) && (side_q[i] == 2'd0);
    end
  end

endmodule
